// File: rtl/multicycle_ctrl_if.sv
// Purpose: bundles the signals between the multi-cycle control FSM and the
//          RV32I datapath (instruction fields, ALU flags, memory handshake in;
//          datapath enables and mux selects out).
// Modports:
//   master - the controller: samples instruction/flag/memory status, drives controls
//   slave  - the datapath: drives instruction/flag/memory status, samples controls
// Memory handshake: the controller holds AdrSrc (and MemWrite for stores)
// steady while an access is outstanding; mem_ready high in a cycle means the
// shared memory port completes that access in that same cycle, and the
// controller advances on that edge. There is no separate request strobe.
interface multicycle_ctrl_if #(
  parameter int ALUCTRL_W = 3,
  parameter int OP_W      = 7
);
  // datapath -> controller
  logic [OP_W-1:0]      op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 Zero;
  logic                 signedLess;
  logic                 unsignedLess;
  logic                 mem_ready;
  // controller -> datapath
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 IRWrite;
  logic                 MemWrite;
  logic                 RegWrite;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 instr_done;
  logic                 illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, signedLess, unsignedLess, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, signedLess, unsignedLess, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose: main control FSM of the multi-cycle RV32I datapath. Sequences
//          fetch / decode / execute / memory / writeback over one shared memory
//          port, one ALU and the register file.
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous reset, active-high; forces all write enables low
//                  in the cycle it is high and returns the FSM to FETCH
//   cbus         - multicycle_ctrl_if.master (instruction fields, flags,
//                  mem_ready in; enables, selects, ALUControl, pulses out)
//   dbg_state_o  - current FSM state encoding, for observation only
module multicycle_ctrl #(
  parameter int ALUCTRL_W = 3,
  parameter int OP_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master cbus,
  output logic [3:0]        dbg_state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_R     = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I     = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_BR    = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(7'b1101111);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(7'b1100111);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(7'b0110111);

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(5);

  state_t state_q, state_d;

  // ungated output values; enables are masked with rst below
  logic                 pcw, adr, irw, mw, rw, done, ill;
  logic [1:0]           src_a, src_b, res_src;
  logic [ALUCTRL_W-1:0] alu;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (cbus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (cbus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (cbus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (cbus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (cbus.mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL,
      S_JALR,
      S_LUI:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // output logic
  always_comb begin
    pcw     = 1'b0;
    adr     = 1'b0;
    irw     = 1'b0;
    mw      = 1'b0;
    rw      = 1'b0;
    done    = 1'b0;
    ill     = 1'b0;
    src_a   = 2'b00;
    src_b   = 2'b00;
    res_src = 2'b00;
    alu     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        // PC <- PC+4 straight from the ALU, loaded together with the IR
        src_b   = 2'b10;
        res_src = 2'b10;
        irw     = cbus.mem_ready;
        pcw     = cbus.mem_ready;
      end
      S_DECODE: begin
        // OldPC + imm computed speculatively: branch/JAL target lands in ALUOut
        src_a = 2'b01;
        src_b = 2'b01;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD: adr = 1'b1;
      S_MEMWB: begin
        res_src = 2'b01;
        rw      = 1'b1;
        done    = 1'b1;
      end
      S_MEMWRITE: begin
        adr  = 1'b1;
        mw   = 1'b1;
        done = cbus.mem_ready;
      end
      S_EXECR, S_EXECI: begin
        src_a = 2'b10;
        src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        // shifts and sltu fall back to add rather than trapping
        case (cbus.funct3)
          3'b000:  alu = (state_q == S_EXECR && cbus.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu = ALU_SLT;
          3'b100:  alu = ALU_XOR;
          3'b110:  alu = ALU_OR;
          3'b111:  alu = ALU_AND;
          default: alu = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      S_BRANCH: begin
        // compare rs1-rs2 while ResultSrc=00 presents the target from ALUOut
        src_a = 2'b10;
        alu   = ALU_SUB;
        done  = 1'b1;
        case (cbus.funct3)
          3'b000:  pcw = cbus.Zero;
          3'b001:  pcw = ~cbus.Zero;
          3'b100:  pcw = cbus.signedLess;
          3'b101:  pcw = ~cbus.signedLess;
          3'b110:  pcw = cbus.unsignedLess;
          3'b111:  pcw = ~cbus.unsignedLess;
          default: pcw = 1'b0;
        endcase
      end
      S_JAL: begin
        // PC <- target in ALUOut; ALU meanwhile forms OldPC+4 for the link
        src_a = 2'b01;
        src_b = 2'b10;
        pcw   = 1'b1;
      end
      S_JALR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        res_src = 2'b10;
        pcw     = 1'b1;
      end
      S_LUI: begin
        // operand A forced to zero so the ALU passes ImmExt through
        src_a = 2'b11;
        src_b = 2'b01;
      end
      S_ILLEGAL: ill = 1'b1;
      default: ;
    endcase
  end

  assign cbus.PCWrite    = pcw  & ~rst;
  assign cbus.IRWrite    = irw  & ~rst;
  assign cbus.MemWrite   = mw   & ~rst;
  assign cbus.RegWrite   = rw   & ~rst;
  assign cbus.instr_done = done & ~rst;
  assign cbus.illegal    = ill  & ~rst;
  assign cbus.AdrSrc     = adr;
  assign cbus.ALUSrcA    = src_a;
  assign cbus.ALUSrcB    = src_b;
  assign cbus.ResultSrc  = res_src;
  assign cbus.ALUControl = alu;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected control sequences built
// from the instruction-class rules, compared cycle by cycle on the falling
// edge, plus literal latency / write-count expectations per instruction.
module tb_multicycle_ctrl;
  localparam int W = 16;
  // bit layout: PCWrite AdrSrc IRWrite MemWrite RegWrite ALUSrcA ALUSrcB ResultSrc ALUControl instr_done illegal
  localparam logic [W-1:0] EN_MASK = 16'hB803;
  localparam logic [W-1:0] ALL     = 16'hFFFF;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;

  logic       clk;
  logic       rst;
  logic [3:0] dbg_state;

  multicycle_ctrl_if #(.ALUCTRL_W(3), .OP_W(7)) cbus ();

  multicycle_ctrl #(.ALUCTRL_W(3), .OP_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .cbus        (cbus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  logic [W-1:0] act;
  assign act = {cbus.PCWrite, cbus.AdrSrc, cbus.IRWrite, cbus.MemWrite, cbus.RegWrite,
                cbus.ALUSrcA, cbus.ALUSrcB, cbus.ResultSrc, cbus.ALUControl,
                cbus.instr_done, cbus.illegal};

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] m;
    string        t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if ((act & m) === (e & m)) n_pass++;
      else $display("FAIL %s: got %h want %h (mask %h, state %0d)", t, act, e, m, dbg_state);
    end
  end

  // model helpers
  function automatic logic [W-1:0] ctl(input logic pcw, input logic adr, input logic irw,
                                       input logic mw, input logic rw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic [2:0] alu, input logic done, input logic ill);
    return {pcw, adr, irw, mw, rw, a, b, rs, alu, done, ill};
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  return sub_sel ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic sl, input logic ul);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return sl;
      3'b101:  return !sl;
      3'b110:  return ul;
      3'b111:  return !ul;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // driver state for the instruction in flight
  int    cyc;
  int    abort_at;
  int    lat;
  int    rw_n;
  int    mw_n;
  logic  aborted;
  string cur_name;

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      cbus.op        = 7'($urandom_range(0, 127));
      cbus.funct3    = 3'($urandom_range(0, 7));
      cbus.mem_ready = rnd();
      cbus.Zero      = rnd();
      exp_q.push_back('0);
      mask_q.push_back(EN_MASK);
      tag_q.push_back({cur_name, "/reset"});
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // one cycle of an instruction: drive mem_ready, queue expectation, observe pulses
  task automatic emit(input logic [W-1:0] e, input logic mr);
    if (abort_at >= 0 && cyc >= abort_at) begin
      if (!aborted) begin
        aborted = 1'b1;
        do_reset(3);
      end
      return;
    end
    cbus.mem_ready = mr;
    exp_q.push_back(e);
    mask_q.push_back(ALL);
    tag_q.push_back(cur_name);
    @(negedge clk);
    #1;
    if ((cbus.instr_done || cbus.illegal) && lat < 0) lat = cyc + 1;
    if (cbus.RegWrite) rw_n++;
    if (cbus.MemWrite) mw_n++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input logic sl, input logic ul,
                           input int fstall, input int mstall, input int abrt);
    logic mr;
    cur_name = name;
    cyc = 0; lat = -1; rw_n = 0; mw_n = 0; abort_at = abrt; aborted = 1'b0;
    cbus.op = op; cbus.funct3 = f3; cbus.funct7b5 = f7;
    cbus.Zero = z; cbus.signedLess = sl; cbus.unsignedLess = ul;
    for (int i = 0; i <= fstall; i++) begin
      mr = (i == fstall);
      emit(ctl(mr, 0, mr, 0, 0, 2'b00, 2'b10, 2'b10, ADD, 0, 0), mr);
    end
    emit(ctl(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, ADD, 0, 0), rnd());
    case (op)
      OP_LOAD, OP_STORE: begin
        emit(ctl(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ADD, 0, 0), rnd());
        for (int i = 0; i <= mstall; i++) begin
          mr = (i == mstall);
          if (op == OP_LOAD) emit(ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0, 0), mr);
          else               emit(ctl(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, ADD, mr, 0), mr);
        end
        if (op == OP_LOAD) emit(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, ADD, 1, 0), rnd());
      end
      OP_R: begin
        emit(ctl(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, alu_of(f3, f7), 0, 0), rnd());
        emit(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 1, 0), rnd());
      end
      OP_I: begin
        emit(ctl(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, alu_of(f3, 1'b0), 0, 0), rnd());
        emit(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 1, 0), rnd());
      end
      OP_BR:
        emit(ctl(taken(f3, z, sl, ul), 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, SUB, 1, 0), rnd());
      OP_JAL: begin
        emit(ctl(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, ADD, 0, 0), rnd());
        emit(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 1, 0), rnd());
      end
      OP_JALR: begin
        emit(ctl(1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, ADD, 0, 0), rnd());
        emit(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 1, 0), rnd());
      end
      OP_LUI: begin
        emit(ctl(0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, ADD, 0, 0), rnd());
        emit(ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, 1, 0), rnd());
      end
      default:
        emit(ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 0, 1), rnd());
    endcase
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    cbus.op = '0; cbus.funct3 = '0; cbus.funct7b5 = 1'b0; cbus.Zero = 1'b0;
    cbus.signedLess = 1'b0; cbus.unsignedLess = 1'b0; cbus.mem_ready = 1'b0;
    cur_name = "init";
    @(posedge clk);
    #1;
    do_reset(3);

    // pin the model against hand-derived values
    check_int("pin_fetch_vec", int'(ctl(1, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, ADD, 0, 0)), 'hA140);
    check_int("pin_sub", int'(alu_of(3'b000, 1'b1)), 1);
    check_int("pin_or", int'(alu_of(3'b110, 1'b0)), 3);
    check_int("pin_bne_z1", int'(taken(3'b001, 1'b1, 1'b0, 1'b0)), 0);
    check_int("pin_bge_lt", int'(taken(3'b101, 1'b0, 1'b1, 1'b0)), 0);

    // fetch stalled once right after reset: IRWrite follows mem_ready
    run_instr("add", OP_R, 3'b000, 1'b0, 0, 0, 0, 1, 0, -1);
    check_int("add_lat", lat, 5);
    run_instr("add2", OP_R, 3'b000, 1'b0, 1, 0, 0, 0, 0, -1);
    check_int("add2_lat", lat, 4);
    check_int("add2_rw", rw_n, 1);
    run_instr("sub", OP_R, 3'b000, 1'b1, 0, 0, 0, 0, 0, -1);
    check_int("sub_lat", lat, 4);
    run_instr("and", OP_R, 3'b111, 1'b0, 0, 0, 0, 0, 0, -1);
    run_instr("slt", OP_R, 3'b010, 1'b0, 0, 0, 0, 0, 0, -1);
    run_instr("addi_f7", OP_I, 3'b000, 1'b1, 0, 0, 0, 0, 0, -1);
    run_instr("xori", OP_I, 3'b100, 1'b0, 0, 0, 0, 0, 0, -1);
    run_instr("ori", OP_I, 3'b110, 1'b0, 0, 0, 0, 0, 0, -1);
    run_instr("slli", OP_I, 3'b001, 1'b0, 0, 0, 0, 0, 0, -1);
    check_int("slli_lat", lat, 4);

    run_instr("lw_stall2", OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 0, 2, -1);
    check_int("lw_stall2_lat", lat, 7);
    check_int("lw_stall2_rw", rw_n, 1);
    run_instr("lw", OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 0, 0, -1);
    check_int("lw_lat", lat, 5);

    run_instr("sw_stall1", OP_STORE, 3'b010, 1'b0, 0, 0, 0, 0, 1, -1);
    check_int("sw_stall1_lat", lat, 5);
    check_int("sw_stall1_mw", mw_n, 2);
    check_int("sw_stall1_rw", rw_n, 0);
    run_instr("sw", OP_STORE, 3'b010, 1'b0, 0, 0, 0, 0, 0, -1);
    check_int("sw_lat", lat, 4);

    run_instr("bne_z1", OP_BR, 3'b001, 1'b0, 1, 0, 0, 0, 0, -1);
    check_int("bne_z1_lat", lat, 3);
    run_instr("bne_z0", OP_BR, 3'b001, 1'b0, 0, 0, 0, 0, 0, -1);
    check_int("bne_z0_lat", lat, 3);
    run_instr("beq_z1", OP_BR, 3'b000, 1'b0, 1, 0, 0, 0, 0, -1);
    run_instr("blt", OP_BR, 3'b100, 1'b0, 0, 1, 0, 0, 0, -1);
    run_instr("bge", OP_BR, 3'b101, 1'b0, 0, 1, 1, 0, 0, -1);
    run_instr("bltu", OP_BR, 3'b110, 1'b0, 1, 0, 1, 0, 0, -1);
    run_instr("bgeu", OP_BR, 3'b111, 1'b0, 0, 0, 0, 0, 0, -1);
    run_instr("br_f3_010", OP_BR, 3'b010, 1'b0, 1, 1, 1, 0, 0, -1);
    run_instr("br_f3_011", OP_BR, 3'b011, 1'b0, 0, 0, 0, 0, 0, -1);

    run_instr("jal", OP_JAL, 3'b000, 1'b0, 0, 0, 0, 0, 0, -1);
    check_int("jal_lat", lat, 4);
    run_instr("jalr", OP_JALR, 3'b000, 1'b0, 0, 0, 0, 0, 0, -1);
    check_int("jalr_lat", lat, 4);
    run_instr("lui", OP_LUI, 3'b101, 1'b1, 0, 0, 0, 0, 0, -1);
    check_int("lui_lat", lat, 4);

    run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 0, 0, 0, 0, 0, -1);
    check_int("illegal_lat", lat, 3);
    check_int("illegal_rw", rw_n, 0);
    check_int("illegal_mw", mw_n, 0);
    run_instr("illegal_7f", 7'b1111111, 3'b111, 1'b1, 1, 1, 1, 0, 0, -1);

    // reset landing in the first MEMWRITE cycle of a stalled store
    run_instr("sw_abort", OP_STORE, 3'b010, 1'b0, 0, 0, 0, 0, 4, 3);
    check_int("sw_abort_mw", mw_n, 0);
    // reset while a load waits in MEMREAD; following fetch stalled twice
    run_instr("lw_abort", OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 0, 3, 4);
    check_int("lw_abort_rw", rw_n, 0);
    run_instr("add_after_rst", OP_R, 3'b100, 1'b0, 0, 0, 0, 2, 0, -1);
    check_int("add_after_rst_lat", lat, 6);

    @(negedge clk);
    #1;
    check_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
